// File: rtl/btn_pkg.sv
// btn_pkg -- shared definitions for the push-button input block.
// Holds the debounce FSM state encoding, the default timing constants
// and a small helper for sizing counters.
package btn_pkg;

   // Debounce FSM states; the 2-bit encoding is fixed so other blocks can decode it.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } btn_state_e;

   // 20 ms of stable input at a 1 MHz clock.
   localparam int BTN_DEBOUNCE_CYC_DEF = 20000;

   // 1 s of hold at a 1 MHz clock.
   localparam int BTN_LONG_CYC_DEF = 1000000;

   // Bits needed to count 0 .. n-1; at least one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the value both flops take during reset, so a caller can make
// the synchronized output start at the pin's idle level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first one a full cycle to resolve metastability.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce -- debounced push button with press / release / long-press pulses.
// The raw pin is synchronized, normalised so that act=1 means pressed, and
// filtered by a four-state FSM: a level change is accepted only after
// DEBOUNCE_CYC consecutive cycles of stable input.
// Optional feature: define BTN_LONG_PRESS_EN to compile in the hold counter
// and the long_press_o pulse; without it long_press_o is tied low.
// "release" is a language keyword, so every data port carries an _i/_o suffix.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYC = BTN_DEBOUNCE_CYC_DEF,
   parameter int LONG_CYC     = BTN_LONG_CYC_DEF,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic btn_raw_i,
   output logic btn_level_o,
   output logic press_o,
   output logic release_o,
   output logic long_press_o
);

   localparam int             DB_W         = cnt_width(DEBOUNCE_CYC);
   localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic           INACTIVE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic            raw_sync;
   logic            act;
   logic            db_done;

   btn_state_e      state_q,   state_d;
   logic [DB_W-1:0] db_cnt_q,  db_cnt_d;
   logic            level_q,   level_d;
   logic            press_q,   press_d;
   logic            release_q, release_d;

   // Hold-counter controls, produced by the FSM.
   logic            hold_clr;
   logic            hold_run;

   // Synchronizer idles at the released pin level so reset never looks like a press.
   sync_2ff #(
      .RST_VAL (INACTIVE_LVL)
   ) u_sync (
      .CLK   (CLK),
      .rst_n (rst_n),
      .d_i   (btn_raw_i),
      .q_o   (raw_sync)
   );

   assign act     = raw_sync ^ INACTIVE_LVL;
   assign db_done = (db_cnt_q == DB_LAST);

   // Next-state, debounce counter and pulse decode for the debounce FSM.
   always_comb begin
      state_d   = state_q;
      db_cnt_d  = db_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      hold_clr  = 1'b0;
      hold_run  = 1'b0;
      case (state_q)
         IDLE: begin
            if (act) begin
               state_d  = PRESS_WAIT;
               db_cnt_d = '0;
            end
         end
         PRESS_WAIT: begin
            if (!act) begin
               // Too short to be a press: drop it silently.
               state_d  = IDLE;
               db_cnt_d = '0;
            end else if (db_done) begin
               state_d  = HELD;
               db_cnt_d = '0;
               press_d  = 1'b1;
               level_d  = 1'b1;
               hold_clr = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         HELD: begin
            hold_run = 1'b1;
            if (!act) begin
               state_d  = REL_WAIT;
               db_cnt_d = '0;
            end
         end
         REL_WAIT: begin
            if (act) begin
               // Release bounce: still the same hold, keep the hold count.
               state_d  = HELD;
               db_cnt_d = '0;
               hold_run = 1'b1;
            end else if (db_done) begin
               // Hold stops counting on the release cycle so long_press
               // can never coincide with the release pulse.
               state_d   = IDLE;
               db_cnt_d  = '0;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
               hold_run = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            db_cnt_d = '0;
         end
      endcase
   end

   // FSM state, debounce counter and registered outputs.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_level_o = level_q;
   assign press_o     = press_q;
   assign release_o   = release_q;

`ifdef BTN_LONG_PRESS_EN
   localparam int                HOLD_W    = cnt_width(LONG_CYC);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              long_q,     long_d;

   // Saturating hold counter; long_press fires only on the step into saturation.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
      if (hold_clr) begin
         hold_cnt_d = '0;
      end else if (hold_run && (hold_cnt_q != HOLD_LAST)) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
         long_d     = (hold_cnt_d == HOLD_LAST);
      end
   end

   // Hold counter and long_press pulse registers.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         long_q     <= long_d;
      end
   end

   assign long_press_o = long_q;
`else
   // Without the long-press feature the hold controls and LONG_CYC go unused.
   localparam int unused_long_cyc = LONG_CYC;
   logic          unused_hold;

   assign unused_hold  = hold_clr ^ hold_run;
   assign long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce -- directed bench for btn_debounce with DEBOUNCE_CYC=4,
// LONG_CYC=10, ACTIVE_LOW=1. Cycle indices are counted from the edge after
// each stimulus change (edge 1 = first synchronizer capture).
// Expectations for long_press follow BTN_LONG_PRESS_EN.
module tb_btn_debounce;
   import btn_pkg::*;

`ifdef BTN_LONG_PRESS_EN
   localparam int LONG_EN = 1;
`else
   localparam int LONG_EN = 0;
`endif

   logic CLK;
   logic rst_n;
   logic btn_raw;
   logic btn_level;
   logic press;
   logic release_p;
   logic long_press;

   int n_checks  = 0;
   int n_fail    = 0;
   int n_overlap = 0;

   int   rel_cyc;
   int   n_press, n_rel, n_long;
   int   at_press, at_rel, at_long, at_rise, at_fall;
   logic lvl_prev;

   btn_debounce #(
      .DEBOUNCE_CYC (4),
      .LONG_CYC     (10),
      .ACTIVE_LOW   (1)
   ) dut (
      .CLK          (CLK),
      .rst_n        (rst_n),
      .btn_raw_i    (btn_raw),
      .btn_level_o  (btn_level),
      .press_o      (press),
      .release_o    (release_p),
      .long_press_o (long_press)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic clr_mon();
      rel_cyc  = 0;
      n_press  = 0;
      n_rel    = 0;
      n_long   = 0;
      at_press = -1;
      at_rel   = -1;
      at_long  = -1;
      at_rise  = -1;
      at_fall  = -1;
      lvl_prev = btn_level;
   endtask

   // Advance n cycles, sampling 1 time unit after each rising edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
         rel_cyc++;
         if (press === 1'b1) begin
            n_press++;
            if (at_press < 0) at_press = rel_cyc;
         end
         if (release_p === 1'b1) begin
            n_rel++;
            if (at_rel < 0) at_rel = rel_cyc;
         end
         if (long_press === 1'b1) begin
            n_long++;
            if (at_long < 0) at_long = rel_cyc;
         end
         if ((int'(press === 1'b1) + int'(release_p === 1'b1) + int'(long_press === 1'b1)) > 1)
            n_overlap++;
         if (btn_level === 1'b1 && lvl_prev !== 1'b1 && at_rise < 0) at_rise = rel_cyc;
         if (btn_level === 1'b0 && lvl_prev === 1'b1 && at_fall < 0) at_fall = rel_cyc;
         lvl_prev = btn_level;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      btn_raw = 1'b1;
      clr_mon();
      run(3);
      check_eq("rst_level",   32'(btn_level),  32'd0);
      check_eq("rst_press",   32'(press),      32'd0);
      check_eq("rst_release", 32'(release_p),  32'd0);
      check_eq("rst_long",    32'(long_press), 32'd0);
      check_eq("rst_state",   32'(dut.state_q), 32'(IDLE));

      rst_n = 1'b1;
      clr_mon();
      run(5);
      check_eq("post_rst_press", n_press, 0);

      // Clean press, held long enough for a long press.
      clr_mon();
      btn_raw = 1'b0;
      run(30);
      check_eq("clean_press_cnt",  n_press, 1);
      check_eq("clean_press_at",   at_press, 7);
      check_eq("clean_level_rise", at_rise, 7);
      check_eq("clean_rel_cnt",    n_rel, 0);
      check_eq("clean_long_cnt",   n_long, LONG_EN);
      check_eq("clean_long_at",    at_long, (LONG_EN != 0) ? 16 : -1);

      // Clean release.
      clr_mon();
      btn_raw = 1'b1;
      run(12);
      check_eq("rel_cnt",        n_rel, 1);
      check_eq("rel_at",         at_rel, 7);
      check_eq("rel_level_fall", at_fall, 7);
      check_eq("rel_press_cnt",  n_press, 0);
      check_eq("rel_long_cnt",   n_long, 0);
      check_eq("rel_state",      32'(dut.state_q), 32'(IDLE));

      // Glitch of three low cycles.
      clr_mon();
      btn_raw = 1'b0;
      run(3);
      btn_raw = 1'b1;
      run(10);
      check_eq("glitch_press_cnt", n_press, 0);
      check_eq("glitch_level",     at_rise, -1);
      check_eq("glitch_state",     32'(dut.state_q), 32'(IDLE));

      // Bouncing press: low 2 / high 1 three times, then stable low.
      clr_mon();
      for (int k = 0; k < 3; k++) begin
         btn_raw = 1'b0;
         run(2);
         btn_raw = 1'b1;
         run(1);
      end
      btn_raw = 1'b0;
      run(30);
      check_eq("bounce_press_cnt", n_press, 1);
      check_eq("bounce_press_at",  at_press, 16);
      check_eq("bounce_long_cnt",  n_long, LONG_EN);
      check_eq("bounce_long_at",   at_long, (LONG_EN != 0) ? 25 : -1);

      // Two-cycle release bounce returns to HELD silently.
      clr_mon();
      btn_raw = 1'b1;
      run(2);
      btn_raw = 1'b0;
      run(12);
      check_eq("relb_rel_cnt",   n_rel, 0);
      check_eq("relb_press_cnt", n_press, 0);
      check_eq("relb_long_cnt",  n_long, 0);
      check_eq("relb_fall",      at_fall, -1);
      check_eq("relb_state",     32'(dut.state_q), 32'(HELD));

      // Reset mid-hold with the button still pressed.
      clr_mon();
      rst_n = 1'b0;
      #1;
      check_eq("arst_level",   32'(btn_level), 32'd0);
      check_eq("arst_press",   32'(press),     32'd0);
      check_eq("arst_release", 32'(release_p), 32'd0);
      run(3);
      check_eq("arst_rel_cnt", n_rel, 0);
      clr_mon();
      rst_n = 1'b1;
      run(12);
      check_eq("rehold_press_cnt", n_press, 1);
      check_eq("rehold_press_at",  at_press, 7);
      check_eq("rehold_rel_cnt",   n_rel, 0);

      // Reset mid-hold with the button released during reset.
      clr_mon();
      rst_n   = 1'b0;
      btn_raw = 1'b1;
      run(3);
      rst_n = 1'b1;
      run(15);
      check_eq("rstrel_rel_cnt",   n_rel, 0);
      check_eq("rstrel_press_cnt", n_press, 0);
      check_eq("rstrel_level",     32'(btn_level), 32'd0);

      check_eq("pulse_overlap", n_overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 20000, stable-input cycles required to accept a level change (20 ms at 1 MHz); legal range >= 2.
REQ-002 SHALL have parameter LONG_CYC, default 1000000, held cycles after accepted press before long_press fires (1 s at 1 MHz); legal range >= 2.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, button polarity: 1 means btn_raw=0 is pressed.
REQ-004 SHALL have port CLK  input  1  system clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn_raw  input  1  asynchronous raw button pin.
REQ-007 SHALL have port btn_level  output  1  debounced level, 1 = pressed, registered.
REQ-008 SHALL have port press  output  1  one-cycle pulse on accepted press.
REQ-009 SHALL have port release  output  1  one-cycle pulse on accepted release.
REQ-010 SHALL have port long_press  output  1  one-cycle pulse once per hold reaching LONG_CYC.

Function
REQ-011 SHALL pass btn_raw through a 2-flop synchronizer, then normalise polarity so that "act" = 1 means pressed.
REQ-012 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, REL_WAIT, with a debounce counter db_cnt sized $clog2(DEBOUNCE_CYC).
REQ-013 IDLE: act=1 -> PRESS_WAIT with db_cnt=0; else remain.
REQ-014 PRESS_WAIT: act=0 -> IDLE (glitch rejected, no output); act=1 and db_cnt==DEBOUNCE_CYC-1 -> HELD; else db_cnt+1.
REQ-015 On PRESS_WAIT->HELD, press SHALL be high for exactly one cycle and btn_level SHALL go 1 in that same cycle; hold counter cleared.
REQ-016 Latency: with t0 = edge where the first synchronizer flop captures stable active input, press SHALL be high in the cycle after edge t0+DEBOUNCE_CYC+2.
REQ-017 HELD: act=0 -> REL_WAIT with db_cnt=0; hold counter increments, saturating at LONG_CYC-1.
REQ-018 REL_WAIT: act=1 -> HELD (release bounce; hold counter preserved, no press pulse); act=0 and db_cnt==DEBOUNCE_CYC-1 -> IDLE with release one-cycle pulse and btn_level=0 in that cycle; else db_cnt+1.
REQ-019 long_press SHALL pulse exactly once, on the cycle the hold counter first reaches LONG_CYC-1 while in HELD or REL_WAIT; no re-fire until the next accepted press.
REQ-020 press, release and long_press SHALL never be high in the same cycle; press and release of one hold are separated by at least DEBOUNCE_CYC cycles.
REQ-021 Counters SHALL never wrap: db_cnt is bounded by FSM exit, hold counter saturates.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, all counters 0, btn_level/press/release/long_press 0.
REQ-023 Synchronizer flops SHALL reset to the inactive pin level (1 if ACTIVE_LOW), so that no spurious press follows reset.
REQ-024 Reset mid-press or mid-hold SHALL produce no release pulse; a button still pressed after reset deassertion SHALL be re-debounced as a fresh press.

Configuration
REQ-025 Macro BTN_LONG_PRESS_EN defined: hold counter and long_press logic SHALL be compiled in per REQ-017/REQ-019.
REQ-026 Macro BTN_LONG_PRESS_EN undefined: hold counter SHALL be omitted, long_press SHALL be tied 0, and all other behaviour SHALL be unchanged.

Structure
REQ-027 Shared package btn_pkg SHALL hold the FSM state encoding (2-bit, IDLE=0, PRESS_WAIT=1, HELD=2, REL_WAIT=3) and the default DEBOUNCE_CYC/LONG_CYC constants.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff (parameterised reset value), reusable by other input blocks.

Verification (sim params DEBOUNCE_CYC=4, LONG_CYC=10, ACTIVE_LOW=1)
REQ-029 Clean press: btn_raw 1->0 captured at t0, held 20 cycles -> single press pulse after edge t0+6, btn_level=1 from that cycle.
REQ-030 Bounce: raw low 2 / high 1 cycles repeated 3x, then stable low -> exactly one press, timed from start of the final stable run.
REQ-031 Glitch: raw low 3 cycles then high -> no press, btn_level stays 0, FSM returns to IDLE.
REQ-032 Long hold 20 cycles with BTN_LONG_PRESS_EN -> one long_press pulse 9 cycles after press; without macro long_press stays 0 throughout.
REQ-033 Release: after HELD, raw high stable -> release pulse after edge (release t0)+6; 2-cycle high bounce in REL_WAIT -> back to HELD, no pulses.
REQ-034 Reset mid-HELD: rst_n low 3 cycles -> all outputs 0 immediately; raw high after reset -> no release pulse; raw still low after reset -> fresh press 6 cycles after deassertion.
